dmem_access_ctrl: RTL and testbench

//  Initiator side of the word-wide data memory port (5-bit word address, WD/WE, registered RD).

---
 rtl/dmem_access_pkg.sv | 37 +++
 rtl/dmem_lane_align.sv | 43 ++++
 rtl/dmem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_pkg.sv
// Shared encodings for the data-memory access controller.
// Size codes, FSM states and lane geometry.
package dmem_access_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_LANES = WORD_W / 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4
  } state_e;

  // Illegal size codes fold into the misaligned path.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      size == SIZE_HALF: bad = off[0];
      size == SIZE_WORD: bad = (off != 2'b00);
      size == SIZE_ILL:  bad = 1'b1;
      default:           bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational; little-endian lanes.
module dmem_lane_align
  import dmem_access_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              sgn_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  bit_off;

  always_comb begin
    bit_off  = {off_i, 3'b000};
    byte_sel = word_i[bit_off +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    merge_o  = wdata_i;
    unique case (1'b1)
      size_i == SIZE_BYTE: begin
        load_o  = {{24{sgn_i & byte_sel[7]}}, byte_sel};
        merge_o = word_i;
        merge_o[bit_off +: 8] = wdata_i[7:0];
      end
      size_i == SIZE_HALF: begin
        load_o  = {{16{sgn_i & half_sel[15]}}, half_sel};
        merge_o = off_i[1] ? {wdata_i[15:0], word_i[15:0]}
                           : {word_i[31:16], wdata_i[15:0]};
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for a word-wide data memory with registered read.
// Sub-word stores go through read-modify-write; all mem_* are registered.
module dmem_access_ctrl
  import dmem_access_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  state_e            state_q;
  logic              ready_q;
  logic              rvalid_q;
  logic              rerr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [DATA_W-1:0] mem_wd_q;
  logic              mem_we_q;

  logic              we_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] load_w;
  logic [DATA_W-1:0] merge_w;
  logic              bad_w;

  assign bad_w = misaligned(req_size, req_addr[1:0]);

  dmem_lane_align u_align (
    .word_i  (mem_rd),
    .off_i   (off_q),
    .size_i  (size_q),
    .sgn_i   (sgn_q),
    .wdata_i (wdata_q),
    .load_o  (load_w),
    .merge_o (merge_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      mem_a_q  <= '0;
      mem_wd_q <= '0;
      mem_we_q <= 1'b0;
      we_q     <= 1'b0;
      off_q    <= '0;
      size_q   <= '0;
      sgn_q    <= 1'b0;
      wdata_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            we_q    <= req_we;
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            sgn_q   <= req_signed;
            wdata_q <= req_wdata;
            mem_a_q <= req_addr[ADDR_W+1:2];
            ready_q <= 1'b0;
            if (bad_w) begin
              rvalid_q <= 1'b1;
              rerr_q   <= 1'b1;
              rdata_q  <= '0;
              state_q  <= ST_RESP;
            end else if (req_we && req_size == SIZE_WORD) begin
              mem_wd_q <= req_wdata;
              mem_we_q <= 1'b1;
              state_q  <= ST_WRITE;
            end else begin
              state_q  <= ST_RD_ISSUE;
            end
          end
        end
        ST_RD_ISSUE: begin
          state_q <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (we_q) begin
            mem_wd_q <= merge_w;
            mem_we_q <= 1'b1;
            state_q  <= ST_WRITE;
          end else begin
            rvalid_q <= 1'b1;
            rerr_q   <= 1'b0;
            rdata_q  <= load_w;
            state_q  <= ST_RESP;
          end
        end
        ST_WRITE: begin
          mem_we_q <= 1'b0;
          rvalid_q <= 1'b1;
          rerr_q   <= 1'b0;
          rdata_q  <= '0;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = rdata_q;
  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table plus back-to-back
// and mid-operation reset sequences, scoreboard on responses.
module tb_dmem_access_ctrl;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [1:0]    req_size = '0;
  logic          req_signed = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;
  logic          mem_we;
  logic [31:0]   mem_rd;

  dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          we_cyc = -1;
  int          n_resp = 0;
  logic [31:0] we_wd = '0;
  logic [31:0] mem [32];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
    mem_rd <= mem[mem_a];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt = we_cnt + 1;
      we_cyc = cyc;
      we_wd  = mem_wd;
    end
    if (resp_valid) begin
      n_resp = n_resp + 1;
      n_cmp  = n_cmp + 1;
      if (sbq.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_resp: got err=%0b rdata=%h, required no response",
                 resp_err, resp_rdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (resp_err !== e.err || resp_rdata !== e.rdata || cyc != e.cyc) begin
          n_bad = n_bad + 1;
          $display("FAIL resp: got err=%0b rdata=%h cyc=%0d, required err=%0b rdata=%h cyc=%0d",
                   resp_err, resp_rdata, cyc, e.err, e.rdata, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [6:0] addr,
                              input logic [1:0] size, input logic sgn,
                              input logic [31:0] wdata, input logic err,
                              input logic [31:0] rdata, input int lat);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.sgn = sgn;
    v.wdata = wdata; v.err = err; v.rdata = rdata; v.lat = lat;
    return v;
  endfunction

  // Drive at negedge, wait for ready, return after the handshake edge.
  task automatic issue(input vec_t v, input bit push, output int t, output int k);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_addr   = v.addr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_wdata  = v.wdata;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL ready_timeout: got req_ready=0 required 1");
    end
    t = cyc;
    if (push) sbq.push_back('{v.err, v.rdata, cyc + v.lat});
    @(posedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL resp_timeout: got %0d pending required 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt[19];

  initial begin
    int t, k, c0, r0;
    int k2, k3;

    vt[0]  = mk(1, 7'h08, 2'b10, 0, 32'hDEADBEEF, 0, 32'h0,        2);
    vt[1]  = mk(0, 7'h08, 2'b10, 0, 32'h0,        0, 32'hDEADBEEF, 3);
    vt[2]  = mk(1, 7'h00, 2'b10, 0, 32'h80017F02, 0, 32'h0,        2);
    vt[3]  = mk(0, 7'h01, 2'b00, 1, 32'h0,        0, 32'h0000007F, 3);
    vt[4]  = mk(0, 7'h03, 2'b00, 1, 32'h0,        0, 32'hFFFFFF80, 3);
    vt[5]  = mk(0, 7'h02, 2'b01, 0, 32'h0,        0, 32'h00008001, 3);
    vt[6]  = mk(0, 7'h02, 2'b01, 1, 32'h0,        0, 32'hFFFF8001, 3);
    vt[7]  = mk(0, 7'h00, 2'b00, 0, 32'h0,        0, 32'h00000002, 3);
    vt[8]  = mk(1, 7'h04, 2'b10, 0, 32'h11223344, 0, 32'h0,        2);
    vt[9]  = mk(1, 7'h06, 2'b00, 0, 32'h123456AA, 0, 32'h0,        4);
    vt[10] = mk(0, 7'h04, 2'b10, 0, 32'h0,        0, 32'h11AA3344, 3);
    vt[11] = mk(1, 7'h02, 2'b01, 0, 32'hFFFFBEEF, 0, 32'h0,        4);
    vt[12] = mk(0, 7'h00, 2'b10, 0, 32'h0,        0, 32'hBEEF7F02, 3);
    vt[13] = mk(0, 7'h05, 2'b10, 0, 32'h0,        1, 32'h0,        1);
    vt[14] = mk(1, 7'h03, 2'b01, 0, 32'h00005555, 1, 32'h0,        1);
    vt[15] = mk(0, 7'h00, 2'b11, 0, 32'h0,        1, 32'h0,        1);
    vt[16] = mk(1, 7'h7C, 2'b10, 0, 32'hCAFEF00D, 0, 32'h0,        2);
    vt[17] = mk(0, 7'h7E, 2'b01, 0, 32'h0,        0, 32'h0000CAFE, 3);
    vt[18] = mk(0, 7'h7F, 2'b00, 1, 32'h0,        0, 32'hFFFFFFCA, 3);

    repeat (2) @(negedge clk);
    chk("rst_req_ready",  {31'b0, req_ready},  32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_err",   {31'b0, resp_err},   32'h0);
    chk("rst_resp_rdata", resp_rdata,          32'h0);
    chk("rst_mem_a",      {27'b0, mem_a},      32'h0);
    chk("rst_mem_wd",     mem_wd,              32'h0);
    chk("rst_mem_we",     {31'b0, mem_we},     32'h0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      c0 = we_cnt;
      issue(vt[i], 1'b1, t, k);
      #1 req_valid = 1'b0;
      drain();
      chk($sformatf("we_count[%0d]", i), we_cnt - c0,
          (vt[i].we && !vt[i].err) ? 1 : 0);
      if (vt[i].we && !vt[i].err)
        chk($sformatf("we_cycle[%0d]", i), we_cyc, t + vt[i].lat - 1);
      if (i == 9) chk("sb_mem_wd", we_wd, 32'h11AA3344);
    end
    chk("mem_word0", mem[0], 32'hBEEF7F02);
    chk("mem_word1_after_err", mem[1], 32'h11AA3344);

    // Three requests with req_valid held high throughout.
    r0 = n_resp;
    issue(mk(0, 7'h08, 2'b10, 0, 32'h0, 0, 32'hDEADBEEF, 3), 1'b1, t, k);
    issue(mk(0, 7'h03, 2'b00, 1, 32'h0, 0, 32'hFFFFFFBE, 3), 1'b1, t, k2);
    issue(mk(1, 7'h10, 2'b10, 0, 32'h00000055, 0, 32'h0, 2), 1'b1, t, k3);
    #1 req_valid = 1'b0;
    drain();
    chk("b2b_busy_wait2", k2, 3);
    chk("b2b_busy_wait3", k3, 3);
    chk("b2b_resp_count", n_resp - r0, 3);
    chk("b2b_mem_word4", mem[4], 32'h00000055);

    // Reset during RD_WAIT of a half store aborts the RMW.
    c0 = we_cnt;
    r0 = n_resp;
    issue(mk(1, 7'h04, 2'b01, 0, 32'h00009999, 0, 32'h0, 4), 1'b0, t, k);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", {31'b0, req_ready}, 32'h1);
    chk("rstmid_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rstmid_mem_we", {31'b0, mem_we}, 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstmid_we_count", we_cnt - c0, 0);
    chk("rstmid_resp_count", n_resp - r0, 0);
    chk("rstmid_mem_word1", mem[1], 32'h11AA3344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
